// File: rtl/clint_timer_if.sv
// Register-port bundle between the memory-mapped bus bridge (master) and the CLINT (slave).
// Single outstanding request; request and response each use a valid/ready handshake.
interface clint_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor for one hart: mtime/mtimecmp timer, msip bit, and the
// machine software/timer interrupt lines, behind a single-outstanding register port.
module clint_timer #(
  parameter int unsigned MTIME_DIV    = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  clint_timer_if.slave  bus,
  output logic          msip_asyn,
  output logic          mtip_asyn
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_MTIMECMP = 16'h4000;
  localparam logic [15:0] ADDR_MTIME    = 16'hBFF8;
  localparam logic [15:0] PRESC_MAX     = 16'(MTIME_DIV - 1);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [63:0] mtimecmp_next;
  logic        msip;
  logic        msip_next;
  logic [15:0] prescaler;
  logic [15:0] prescaler_next;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        tick;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic        addr_ok;
  logic        wr;
  logic        wr_time;
  logic [63:0] read_val;

  function automatic logic [63:0] merge_bytes(input logic [63:0] cur,
                                              input logic [63:0] wdat,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = cur;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Exact-address decode also rejects misaligned offsets; a register write in
  // the accept cycle takes priority over that cycle's timer increment.
  always_comb begin
    accept   = (state == IDLE) && bus.req_valid;
    tick     = (prescaler == PRESC_MAX);
    hit_msip = (bus.req_addr == ADDR_MSIP);
    hit_cmp  = (bus.req_addr == ADDR_MTIMECMP);
    hit_time = (bus.req_addr == ADDR_MTIME);
    addr_ok  = hit_msip || hit_cmp || hit_time;
    wr       = accept && bus.req_wen;
    wr_time  = wr && hit_time && (bus.req_wstrb != 8'h00);

    mtime_next     = tick ? mtime + 64'd1 : mtime;
    prescaler_next = tick ? 16'd0 : prescaler + 16'd1;
    if (wr_time) begin
      mtime_next     = merge_bytes(mtime, bus.req_wdata, bus.req_wstrb);
      prescaler_next = 16'd0;
    end

    mtimecmp_next = mtimecmp;
    if (wr && hit_cmp) mtimecmp_next = merge_bytes(mtimecmp, bus.req_wdata, bus.req_wstrb);

    msip_next = msip;
    if (wr && hit_msip && bus.req_wstrb[0]) msip_next = bus.req_wdata[0];

    read_val = 64'd0;
    if (hit_msip)      read_val = {63'd0, msip};
    else if (hit_cmp)  read_val = mtimecmp;
    else if (hit_time) read_val = mtime;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= 64'd0;
      mtimecmp  <= MTIMECMP_RST;
      msip      <= 1'b0;
      prescaler <= 16'd0;
      mtip_asyn <= 1'b0;
      rdata_q   <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      mtime     <= mtime_next;
      mtimecmp  <= mtimecmp_next;
      msip      <= msip_next;
      prescaler <= prescaler_next;
      mtip_asyn <= (mtime_next >= mtimecmp_next);
      if (accept) begin
        rdata_q <= (!bus.req_wen && addr_ok) ? read_val : 64'd0;
        err_q   <= !addr_ok;
      end
    end
  end

  assign msip_asyn      = msip;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance with MTIME_DIV=1 and one with MTIME_DIV=4
// share the clock and reset; a select signal steers the common request driver.
module tb_clint_timer;

  logic        clk;
  logic        rst;
  logic        sel4;
  logic        req_valid;
  logic        req_wen;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_ready;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        msip1, mtip1, msip4, mtip4;
  logic [63:0] cyc;

  int checks;
  int errors;

  clint_timer_if bus1 ();
  clint_timer_if bus4 ();

  assign bus1.req_valid  = req_valid && !sel4;
  assign bus1.req_wen    = req_wen;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.req_wstrb  = req_wstrb;
  assign bus1.resp_ready = resp_ready && !sel4;
  assign bus4.req_valid  = req_valid && sel4;
  assign bus4.req_wen    = req_wen;
  assign bus4.req_addr   = req_addr;
  assign bus4.req_wdata  = req_wdata;
  assign bus4.req_wstrb  = req_wstrb;
  assign bus4.resp_ready = resp_ready && sel4;

  assign req_ready  = sel4 ? bus4.req_ready  : bus1.req_ready;
  assign resp_valid = sel4 ? bus4.resp_valid : bus1.resp_valid;
  assign resp_rdata = sel4 ? bus4.resp_rdata : bus1.resp_rdata;
  assign resp_err   = sel4 ? bus4.resp_err   : bus1.resp_err;

  clint_timer #(.MTIME_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .msip_asyn(msip1), .mtip_asyn(mtip1)
  );

  clint_timer #(.MTIME_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .msip_asyn(msip4), .mtip_asyn(mtip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals mtime of the MTIME_DIV=1 instance, whose mtime is never written.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 64'd0;
    else     cyc <= cyc + 64'd1;
  end

  typedef struct {
    string       name;
    logic        wen;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic        exp_msip;
    logic        exp_mtip;
  } vec_t;

  vec_t vecs[16];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic s4, input logic wen, input logic [15:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wstrb,
                                output logic [63:0] rdata, output logic err, output logic [1:0] irq);
    int budget;
    sel4 = s4; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("resp_valid_next_cycle", 64'(resp_valid), 64'd1);
    budget = 0;
    while (!resp_valid && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    irq   = s4 ? {msip4, mtip4} : {msip1, mtip1};
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout: got resp_valid=0 expected 1 within 8 cycles");
    end else begin
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [1:0]  irq;
    logic [63:0] exp_t;

    checks = 0; errors = 0;
    rst = 1'b1; sel4 = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = 16'h0; req_wdata = 64'h0; req_wstrb = 8'h0; resp_ready = 1'b0;

    vecs[0]  = '{"msip_wr_all",      1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"msip_rd_one",      1'b0, 16'h0000, 64'h0,                   8'h00, 64'h1,                   1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"msip_wr_zero",     1'b1, 16'h0000, 64'h0,                   8'hFF, 64'h0,                   1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"msip_rd_zero",     1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0,                   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"cmp_wr_strobe0f",  1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0,                   1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"cmp_rd_merged",    1'b0, 16'h4000, 64'h0,                   8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"cmp_wr_wstrb0",    1'b1, 16'h4000, 64'h0,                   8'h00, 64'h0,                   1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"cmp_rd_after_nop", 1'b0, 16'h4000, 64'h0,                   8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"rd_0004_err",      1'b0, 16'h0004, 64'h0,                   8'h00, 64'h0,                   1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"wr_0004_err",      1'b1, 16'h0004, 64'h1,                   8'hFF, 64'h0,                   1'b1, 1'b0, 1'b0};
    vecs[10] = '{"rd_2000_err",      1'b0, 16'h2000, 64'h0,                   8'h00, 64'h0,                   1'b1, 1'b0, 1'b0};
    vecs[11] = '{"wr_2000_err",      1'b1, 16'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b1, 1'b0, 1'b0};
    vecs[12] = '{"wr_4004_err",      1'b1, 16'h4004, 64'h0,                   8'hFF, 64'h0,                   1'b1, 1'b0, 1'b0};
    vecs[13] = '{"cmp_unchanged",    1'b0, 16'h4000, 64'h0,                   8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"msip_unchanged",   1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0,                   1'b0, 1'b0, 1'b0};
    vecs[15] = '{"wr_bffc_err",      1'b1, 16'hBFFC, 64'h0,                   8'hFF, 64'h0,                   1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check_output("rst_req_ready",  64'(bus1.req_ready),  64'd1);
    check_output("rst_resp_valid", 64'(bus1.resp_valid), 64'd0);
    check_output("rst_resp_rdata", bus1.resp_rdata,      64'd0);
    check_output("rst_resp_err",   64'(bus1.resp_err),   64'd0);
    check_output("rst_msip",       64'(msip1),           64'd0);
    check_output("rst_mtip",       64'(mtip1),           64'd0);
    check_output("rst_mtip_div4",  64'(mtip4),           64'd0);
    rst = 1'b0;

    // Read of mtime presented in cycle 5 returns 5, response visible in cycle 6
    repeat (5) @(negedge clk);
    sel4 = 1'b0; req_wen = 1'b0; req_addr = 16'hBFF8; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("t1_resp_valid", 64'(resp_valid), 64'd1);
    check_output("t1_rdata",      resp_rdata,      64'd5);
    check_output("t1_err",        64'(resp_err),   64'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("t1_resp_done", 64'(resp_valid), 64'd0);

    // mtimecmp=20: mtip tracks mtime >= 20, then falls when mtimecmp is raised
    apply_stimulus(1'b0, 1'b1, 16'h4000, 64'd20, 8'hFF, rd, er, irq);
    check_output("t2_cmp_wr_err", 64'(er), 64'd0);
    while (cyc < 64'd26) begin
      check_output("t2_mtip_vs_20", 64'(mtip1), 64'(cyc >= 64'd20));
      @(negedge clk);
    end
    apply_stimulus(1'b0, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, irq);
    check_output("t2_mtip_fall", 64'(irq[0]), 64'd0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, irq);
      check_output({vecs[i].name, "_rdata"}, rd,              vecs[i].exp_rdata);
      check_output({vecs[i].name, "_err"},   64'(er),         64'(vecs[i].exp_err));
      check_output({vecs[i].name, "_msip"},  64'(irq[1]),     64'(vecs[i].exp_msip));
      check_output({vecs[i].name, "_mtip"},  64'(irq[0]),     64'(vecs[i].exp_mtip));
    end

    // MTIME_DIV=4 wrap: write near the top, expect one increment every 4 cycles
    apply_stimulus(1'b1, 1'b1, 16'h4000, 64'h0, 8'hFF, rd, er, irq);
    check_output("t4_cmp0_mtip", 64'(irq[0]), 64'd1);
    sel4 = 1'b1; req_wen = 1'b1; req_addr = 16'hBFF8;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFE; req_wstrb = 8'hFF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_t = (k < 4) ? 64'hFFFF_FFFF_FFFF_FFFE : (k < 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      check_output("t4_mtime", dut4.mtime, exp_t);
      check_output("t4_mtip",  64'(mtip4), 64'd1);
      resp_ready = (k == 0);
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, er, irq);
    check_output("t4_rd_wrapped", rd, 64'h0);

    // Stalled error response, a queued request, then reset during RESP
    sel4 = 1'b0; req_wen = 1'b0; req_addr = 16'h2000; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 16'h4000;
    for (int k = 0; k < 3; k++) begin
      check_output("t6_hold_valid", 64'(resp_valid), 64'd1);
      check_output("t6_hold_err",   64'(resp_err),   64'd1);
      check_output("t6_hold_rdata", resp_rdata,      64'd0);
      check_output("t6_hold_ready", 64'(req_ready),  64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check_output("t6_idle_valid", 64'(resp_valid), 64'd0);
    check_output("t6_idle_ready", 64'(req_ready),  64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_output("t6_queued_valid", 64'(resp_valid), 64'd1);
    check_output("t6_queued_err",   64'(resp_err),   64'd0);
    check_output("t6_queued_rdata", resp_rdata,      64'hFFFF_FFFF_5566_7788);
    rst = 1'b1;
    #1;
    check_output("t6_rst_valid", 64'(bus1.resp_valid), 64'd0);
    check_output("t6_rst_ready", 64'(bus1.req_ready),  64'd1);
    check_output("t6_rst_mtime", dut1.mtime,           64'd0);
    check_output("t6_rst_mtip",  64'(mtip1),           64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'h4000, 64'h0, 8'h00, rd, er, irq);
    check_output("t6_cmp_after_rst", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
